// File: rtl/pipe_hazard_fwd_ctrl.sv
// Hazard / forwarding controller for the 5-stage pipeline: scoreboard of in-flight
// destinations, load-use stalls, registered EX forwarding selects and branch flush.

module pipe_hazard_fwd_src #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int FSW    = 2
) (
  input  logic [REG_AW-1:0]            src,
  input  logic                         use_src,
  input  logic [DEPTH-1:0]             sb_valid,
  input  logic [DEPTH-1:0][REG_AW-1:0] sb_dest,
  output logic [DEPTH-1:0]             hit,
  output logic [FSW-1:0]               sel
);
  always_comb begin
    hit = '0;
    for (int k = 0; k < DEPTH; k++)
      hit[k] = use_src && sb_valid[k] && (sb_dest[k] == src);
  end

  // Scan oldest to youngest so the youngest producer wins; the WB slot is never a source.
  always_comb begin
    sel = '0;
    for (int k = DEPTH-2; k >= 0; k--)
      if (hit[k]) sel = FSW'(k + 1);
  end
endmodule

module pipe_hazard_fwd_ctrl #(
  parameter int REG_AW    = 5,
  parameter int DEPTH     = 3,
  parameter bit FWD_EN    = 1'b1,
  parameter bit WB_BYPASS = 1'b1,
  parameter int BR_STAGE  = 1,
  localparam int FSW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              br_taken,
  output logic              pcwrite,
  output logic              if_id_write,
  output logic              bubble,
  output logic              flush,
  output logic [FSW-1:0]    fwd_a,
  output logic [FSW-1:0]    fwd_b,
  output logic [15:0]       stall_cnt
);
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              is_load;
  } sb_entry_t;

  // Slots whose match always stalls; a load in EX is handled separately.
  localparam logic [DEPTH-1:0] STALL_MASK =
    {1'b0, {(DEPTH-1){!FWD_EN}}} | {!WB_BYPASS, {(DEPTH-1){1'b0}}};

  logic [DEPTH-1:0]             sb_valid;
  logic [DEPTH-1:0][REG_AW-1:0] sb_dest;
  logic                         sb0_load;   // load flag only matters while the load sits in EX
  sb_entry_t                    id_entry;

  logic [1:0][REG_AW-1:0] src;
  logic [1:0]             use_src;
  logic [1:0][DEPTH-1:0]  hit;
  logic [1:0][FSW-1:0]    sel;
  logic [DEPTH-1:0]       any_hit;
  logic                   hazard, stall;

  assign src     = {id_rt, id_rs};
  assign use_src = {id_use_rt, id_use_rs};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_op
      pipe_hazard_fwd_src #(.REG_AW(REG_AW), .DEPTH(DEPTH), .FSW(FSW)) u_src (
        .src      (src[i]),
        .use_src  (use_src[i]),
        .sb_valid (sb_valid),
        .sb_dest  (sb_dest),
        .hit      (hit[i]),
        .sel      (sel[i])
      );
    end
  endgenerate

  // id_rs == id_rt collapses here, so a shared source yields one stall.
  assign any_hit = hit[0] | hit[1];
  assign hazard  = (|(any_hit & STALL_MASK)) || (FWD_EN && any_hit[0] && sb0_load);
  assign stall   = hazard && !br_taken;

  assign pcwrite     = !stall;
  assign if_id_write = !stall;
  assign bubble      = stall;
  assign flush       = br_taken;

  assign id_entry = '{valid:   id_regwrite && (id_dest != '0),
                      dest:    id_dest,
                      is_load: id_memread};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_valid  <= '0;
      sb_dest   <= '0;
      sb0_load  <= 1'b0;
      fwd_a     <= '0;
      fwd_b     <= '0;
      stall_cnt <= '0;
    end else if (ce) begin
      for (int k = 1; k < DEPTH; k++) begin
        sb_valid[k] <= sb_valid[k-1] && !(br_taken && (k <= BR_STAGE));
        sb_dest[k]  <= sb_dest[k-1];
      end
      sb_valid[0] <= id_entry.valid && !stall && !br_taken;
      sb_dest[0]  <= id_entry.dest;
      sb0_load    <= id_entry.is_load;
      if (stall || br_taken || !FWD_EN) begin
        fwd_a <= '0;
        fwd_b <= '0;
      end else begin
        fwd_a <= sel[0];
        fwd_b <= sel[1];
      end
      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_fwd_ctrl.sv
// Bench for pipe_hazard_fwd_ctrl: four parameter configurations share one stimulus
// stream and are compared every cycle against a distance-based pipeline model.

module tb_pipe_hazard_fwd_ctrl;
  logic clk = 1'b0;
  logic rst_n, ce;
  logic [4:0] id_rs, id_rt, id_dest;
  logic id_use_rs, id_use_rt, id_regwrite, id_memread, br_taken;
  logic [3:0] pcw, ifw, bub, fl;
  logic [1:0] fa0, fb0, fa1, fb1, fa2, fb2;
  logic [2:0] fa3, fb3;
  logic [15:0] cnt0, cnt1, cnt2, cnt3;

  always #5 clk = ~clk;

  pipe_hazard_fwd_ctrl #(.DEPTH(3), .FWD_EN(1'b1), .WB_BYPASS(1'b1), .BR_STAGE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_dest(id_dest),
    .br_taken(br_taken), .pcwrite(pcw[0]), .if_id_write(ifw[0]), .bubble(bub[0]), .flush(fl[0]),
    .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(cnt0));
  pipe_hazard_fwd_ctrl #(.DEPTH(3), .FWD_EN(1'b0), .WB_BYPASS(1'b1), .BR_STAGE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_dest(id_dest),
    .br_taken(br_taken), .pcwrite(pcw[1]), .if_id_write(ifw[1]), .bubble(bub[1]), .flush(fl[1]),
    .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(cnt1));
  pipe_hazard_fwd_ctrl #(.DEPTH(3), .FWD_EN(1'b0), .WB_BYPASS(1'b0), .BR_STAGE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_dest(id_dest),
    .br_taken(br_taken), .pcwrite(pcw[2]), .if_id_write(ifw[2]), .bubble(bub[2]), .flush(fl[2]),
    .fwd_a(fa2), .fwd_b(fb2), .stall_cnt(cnt2));
  pipe_hazard_fwd_ctrl #(.DEPTH(5), .FWD_EN(1'b1), .WB_BYPASS(1'b0), .BR_STAGE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_dest(id_dest),
    .br_taken(br_taken), .pcwrite(pcw[3]), .if_id_write(ifw[3]), .bubble(bub[3]), .flush(fl[3]),
    .fwd_a(fa3), .fwd_b(fb3), .stall_cnt(cnt3));

  int cfg_d[4] = '{3, 3, 3, 5};
  int cfg_b[4] = '{1, 1, 1, 3};
  bit cfg_f[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit cfg_w[4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  int n_chk = 0;
  int n_err = 0;

  // Model: slot d-1 holds the producer d stages ahead of ID.
  bit         mv[4][8];
  logic [4:0] md[4][8];
  bit         ml[4][8];
  int         mfa[4], mfb[4], mcnt[4];

  typedef struct {
    logic [4:0] rs, rt, dst;
    bit urs, urt, rw, mr, br, est, efl;
    int efa, efb, ecnt;
  } vec_t;
  vec_t tbl[15];

  function automatic vec_t mk(int rs, int rt, int urs, int urt, int rw, int mr, int dst, int br,
                              int est, int efl, int efa, int efb, int ecnt);
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.dst = 5'(dst);
    v.urs = (urs != 0); v.urt = (urt != 0); v.rw = (rw != 0); v.mr = (mr != 0); v.br = (br != 0);
    v.est = (est != 0); v.efl = (efl != 0);
    v.efa = efa; v.efb = efb; v.ecnt = ecnt;
    return v;
  endfunction

  function automatic int get_fa(int c);
    case (c) 0: return int'(fa0); 1: return int'(fa1); 2: return int'(fa2); default: return int'(fa3); endcase
  endfunction
  function automatic int get_fb(int c);
    case (c) 0: return int'(fb0); 1: return int'(fb1); 2: return int'(fb2); default: return int'(fb3); endcase
  endfunction
  function automatic int get_cnt(int c);
    case (c) 0: return int'(cnt0); 1: return int'(cnt1); 2: return int'(cnt2); default: return int'(cnt3); endcase
  endfunction

  function automatic bit reads(logic [4:0] r);
    return (id_use_rs && id_rs == r) || (id_use_rt && id_rt == r);
  endfunction

  // A needed producer is unreachable if it is a load one stage ahead, if forwarding
  // is off and it is not yet in WB, or if it is in WB without write-through.
  function automatic bit m_stall(int c);
    bit haz;
    haz = 1'b0;
    for (int d = 1; d <= cfg_d[c]; d++)
      if (mv[c][d-1] && reads(md[c][d-1])) begin
        if (d == cfg_d[c]) begin
          if (!cfg_w[c]) haz = 1'b1;
        end else if (!cfg_f[c] || (d == 1 && ml[c][0])) haz = 1'b1;
      end
    return haz && !br_taken;
  endfunction

  function automatic int m_sel(int c, logic [4:0] r, bit u);
    if (!u) return 0;
    for (int d = 1; d < cfg_d[c]; d++)
      if (mv[c][d-1] && md[c][d-1] == r) return d;
    return 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 8; k++) begin mv[c][k] = 1'b0; md[c][k] = '0; ml[c][k] = 1'b0; end
      mfa[c] = 0; mfb[c] = 0; mcnt[c] = 0;
    end
  endtask

  task automatic model_tick();
    for (int c = 0; c < 4; c++) begin
      bit st;
      st = m_stall(c);
      if (ce) begin
        if (st || br_taken || !cfg_f[c]) begin mfa[c] = 0; mfb[c] = 0; end
        else begin mfa[c] = m_sel(c, id_rs, id_use_rs); mfb[c] = m_sel(c, id_rt, id_use_rt); end
        if (st && mcnt[c] < 65535) mcnt[c]++;
        for (int k = cfg_d[c]-1; k >= 1; k--) begin
          mv[c][k] = mv[c][k-1] && !(br_taken && k <= cfg_b[c]);
          md[c][k] = md[c][k-1];
          ml[c][k] = ml[c][k-1];
        end
        mv[c][0] = id_regwrite && id_dest != 0 && !st && !br_taken;
        md[c][0] = id_dest;
        ml[c][0] = id_memread;
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 4; c++) begin
      bit st;
      st = m_stall(c);
      chk($sformatf("c%0d pcwrite", c), int'(pcw[c]), int'(!st));
      chk($sformatf("c%0d if_id_write", c), int'(ifw[c]), int'(!st));
      chk($sformatf("c%0d bubble", c), int'(bub[c]), int'(st));
      chk($sformatf("c%0d flush", c), int'(fl[c]), int'(br_taken));
      chk($sformatf("c%0d fwd_a", c), get_fa(c), mfa[c]);
      chk($sformatf("c%0d fwd_b", c), get_fb(c), mfb[c]);
      chk($sformatf("c%0d stall_cnt", c), get_cnt(c), mcnt[c]);
    end
  endtask

  task automatic set_in(int rs, int rt, int urs, int urt, int rw, int mr, int dst, int br);
    id_rs = 5'(rs); id_rt = 5'(rt); id_dest = 5'(dst);
    id_use_rs = (urs != 0); id_use_rt = (urt != 0);
    id_regwrite = (rw != 0); id_memread = (mr != 0); br_taken = (br != 0);
  endtask

  task automatic advance();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    advance();
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // lw/add, forwarding distances, r0, flush over a pending load-use, shared rs==rt
    tbl[0]  = mk( 1,  0, 1, 0, 1, 1,  8, 0,  0, 0, 0, 0, 0);
    tbl[1]  = mk( 8,  2, 1, 1, 1, 0,  9, 0,  1, 0, 0, 0, 0);
    tbl[2]  = mk( 8,  2, 1, 1, 1, 0,  9, 0,  0, 0, 0, 0, 1);
    tbl[3]  = mk( 1,  2, 1, 1, 1, 0,  8, 0,  0, 0, 2, 0, 1);
    tbl[4]  = mk( 4,  8, 1, 1, 1, 0,  3, 0,  0, 0, 0, 0, 1);
    tbl[5]  = mk( 8,  6, 1, 1, 1, 0,  5, 0,  0, 0, 0, 1, 1);
    tbl[6]  = mk( 1,  0, 1, 0, 1, 0,  0, 0,  0, 0, 2, 0, 1);
    tbl[7]  = mk( 0,  0, 1, 1, 1, 0,  3, 0,  0, 0, 0, 0, 1);
    tbl[8]  = mk( 1,  0, 1, 0, 1, 1, 10, 0,  0, 0, 0, 0, 1);
    tbl[9]  = mk(10, 10, 1, 1, 1, 0, 11, 1,  0, 1, 0, 0, 1);
    tbl[10] = mk(10, 10, 1, 1, 1, 0, 11, 0,  0, 0, 0, 0, 1);
    tbl[11] = mk(11,  0, 1, 0, 1, 1, 12, 0,  0, 0, 0, 0, 1);
    tbl[12] = mk(12, 12, 1, 1, 1, 0, 13, 0,  1, 0, 1, 0, 1);
    tbl[13] = mk(12, 12, 1, 1, 1, 0, 13, 0,  0, 0, 0, 0, 2);
    tbl[14] = mk( 0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 2, 2, 2);

    rst_n = 1'b0; ce = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12 rst_n = 1'b1;
    advance();

    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].rw, tbl[i].mr, tbl[i].dst, tbl[i].br);
      @(negedge clk);
      check_all();
      chk($sformatf("vec%0d stall", i), int'(!pcw[0]), int'(tbl[i].est));
      chk($sformatf("vec%0d bubble", i), int'(bub[0]), int'(tbl[i].est));
      chk($sformatf("vec%0d flush", i), int'(fl[0]), int'(tbl[i].efl));
      chk($sformatf("vec%0d fwd_a", i), int'(fa0), tbl[i].efa);
      chk($sformatf("vec%0d fwd_b", i), int'(fb0), tbl[i].efb);
      chk($sformatf("vec%0d stall_cnt", i), int'(cnt0), tbl[i].ecnt);
      advance();
    end

    // Reset mid-run with three valid entries and a stall pending.
    do_reset();
    set_in(1, 0, 1, 0, 1, 1, 4, 0); step();
    set_in(4, 4, 1, 1, 1, 0, 5, 0); step(); step();
    set_in(5, 0, 1, 0, 1, 0, 6, 0); step();
    set_in(6, 0, 1, 0, 1, 1, 7, 0); step();
    set_in(7, 7, 1, 1, 1, 0, 9, 0);
    @(negedge clk);
    check_all();
    chk("pre_rst pcwrite", int'(pcw[0]), 0);
    chk("pre_rst fwd_a", int'(fa0), 1);
    chk("pre_rst stall_cnt", int'(cnt0), 1);
    do_reset();
    chk("rst pcwrite", int'(pcw[0]), 1);
    chk("rst if_id_write", int'(ifw[0]), 1);
    chk("rst bubble", int'(bub[0]), 0);
    chk("rst fwd_a", int'(fa0), 0);
    chk("rst fwd_b", int'(fb0), 0);
    chk("rst stall_cnt", int'(cnt0), 0);
    advance();

    // Clock enable low freezes the counter while the stall stays visible.
    do_reset();
    set_in(1, 0, 1, 0, 1, 1, 8, 0); step();
    ce = 1'b0;
    set_in(8, 8, 1, 1, 1, 0, 9, 0); step(); step();
    @(negedge clk);
    chk("ce0 pcwrite", int'(pcw[0]), 0);
    chk("ce0 stall_cnt", int'(cnt0), 0);
    advance();
    ce = 1'b1; step();
    @(negedge clk);
    chk("ce1 stall_cnt", int'(cnt0), 1);
    chk("ce1 pcwrite", int'(pcw[0]), 1);
    advance();

    // No forwarding: dependent add waits for WB (2 cycles) or retirement (3 cycles).
    do_reset();
    set_in(1, 2, 1, 1, 1, 0, 8, 0); step();
    set_in(8, 8, 1, 1, 1, 0, 9, 0); step(); step(); step(); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();
    @(negedge clk);
    chk("nofwd_wb stall_cnt", int'(cnt1), 2);
    chk("nofwd_nowb stall_cnt", int'(cnt2), 3);
    chk("fwd stall_cnt", int'(cnt0), 0);
    check_all();
    advance();

    do_reset();
    for (int i = 0; i < 600; i++) begin
      ce = ($urandom_range(7) != 0);
      set_in(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(1)),
             int'($urandom_range(1)), int'($urandom_range(3) != 0), int'($urandom_range(2) == 0),
             int'($urandom_range(3)), int'($urandom_range(7) == 0));
      if ($urandom_range(99) == 0) do_reset();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
